sram_responder: RTL

- Responder end of the byte-lane SRAM interface driven by the load/store unit.
- Accepts ce/we/word-address/lane-select/write-data requests and holds a word-addressed storage array.
- Performs lane-masked writes and full-word reads; the initiator extracts lanes itself.
- Adds registered timing: configurable wait states, a one-cycle ack pulse, a busy flag, and an optional post-reset clear sweep.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_byte_array.sv | 39 +++
 rtl/sram_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the byte-lane SRAM responder.
package sram_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int LANE_W = DATA_W / SEL_W;
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        CLEAR
    } state_t;

    // Lowest data bit carried by a lane; lane 3 is [31:24], lane 0 is [7:0].
    function automatic int lane_lsb(input int lane);
        return lane * LANE_W;
    endfunction

endpackage

// File: rtl/sram_byte_array.sv
// Word-addressed storage with per-lane write enables and a registered,
// hold-until-next-read output port.
module sram_byte_array
    import sram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array has no reset; resetting it would turn RAM into flops.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int l = 0; l < SEL_W; l++) begin
                if (sel[l]) begin
                    mem[addr][lane_lsb(l) +: LANE_W] <= wdata[lane_lsb(l) +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Responder end of the byte-lane SRAM interface with wait states and ack.
// Optional post-reset clear sweep: define SRAM_INIT_CLEAR_EN.
module sram_responder
    import sram_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sram_ce,
    input  logic              sram_we,
    input  logic [31:0]       sram_addr_i,
    input  logic [SEL_W-1:0]  sram_sel_i,
    input  logic [DATA_W-1:0] sram_data_i,
    output logic [DATA_W-1:0] sram_data_o,
    output logic              sram_ack,
    output logic              sram_busy
);

    state_t                state, state_nxt;
    logic [WCNT_W-1:0]     wcnt, wcnt_nxt;
    logic                  accept;

    logic                  req_we;
    logic [DEPTH_LOG2-1:0] req_addr;
    logic [SEL_W-1:0]      req_sel;
    logic [DATA_W-1:0]     req_data;

    logic                  mem_en, mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [SEL_W-1:0]      mem_sel;
    logic [DATA_W-1:0]     mem_wdata;

    // Upper address bits alias onto the array and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^sram_addr_i[31:DEPTH_LOG2];

`ifdef SRAM_INIT_CLEAR_EN
    logic                  clear_pend;
    logic [DEPTH_LOG2-1:0] clr_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_pend <= 1'b1;
            clr_addr   <= '0;
        end else if (state == CLEAR) begin
            clear_pend <= 1'b0;
            clr_addr   <= clr_addr + 1'b1;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we   <= 1'b0;
            req_addr <= '0;
            req_sel  <= '0;
            req_data <= '0;
        end else if (accept) begin
            req_we   <= sram_we;
            req_addr <= sram_addr_i[DEPTH_LOG2-1:0];
            req_sel  <= sram_sel_i;
            req_data <= sram_data_i;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        accept    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = req_we;
        mem_addr  = req_addr;
        mem_sel   = req_sel;
        mem_wdata = req_data;

        case (state)
            IDLE: begin
`ifdef SRAM_INIT_CLEAR_EN
                if (clear_pend) begin
                    state_nxt = CLEAR;
                end else
`endif
                if (sram_ce) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access happens on the accept edge,
                        // so it must use the live request rather than the latch.
                        state_nxt = ACK;
                        mem_en    = 1'b1;
                        mem_we    = sram_we;
                        mem_addr  = sram_addr_i[DEPTH_LOG2-1:0];
                        mem_sel   = sram_sel_i;
                        mem_wdata = sram_data_i;
                    end else begin
                        state_nxt = WAIT;
                        wcnt_nxt  = WCNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (wcnt == '0) begin
                    state_nxt = ACK;
                    mem_en    = 1'b1;
                end else begin
                    wcnt_nxt = wcnt - 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
`ifdef SRAM_INIT_CLEAR_EN
            CLEAR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_addr;
                mem_sel   = '1;
                mem_wdata = '0;
                if (clr_addr == '1) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sram_ack  = (state == ACK);
    assign sram_busy = (state != IDLE);

    sram_byte_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .sel   (mem_sel),
        .wdata (mem_wdata),
        .rdata (sram_data_o)
    );

endmodule
